axi_stream_crc_arbiter: RTL and testbench
=========================================

Name: axi_stream_crc_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one sideband-CRC datapath between NUM_SRC AXI-Stream sources.
- Grants one source at a time and holds the grant until that source's tlast beat transfers.
- Forwards the granted source's beats unmodified to the CRC stage, tagged with the source index.
- Sits directly upstream of the sideband CRC block and keeps per-packet CRC context unambiguous.

Parameters:
- DATA_WIDTH, 512, tdata width per source.
- KEEP_BYTES, DATA_WIDTH/8, tkeep width per source.
- NUM_SRC, 4, number of requesting sources (2..16).
- SRC_W, $clog2(NUM_SRC), width of the source-index tag.

Ports:
- clk  in  1  clock; all logic rising-edge.
- srst  in  1  synchronous active-high reset.
- i_s_tvalid  in  NUM_SRC  per-source valid.
- i_s_tdata  in  NUM_SRC*DATA_WIDTH  per-source data, source k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_s_tkeep  in  NUM_SRC*KEEP_BYTES  per-source keep, same packing as tdata.
- i_s_tlast  in  NUM_SRC  per-source last.
- o_s_tready  out  NUM_SRC  per-source ready.
- o_m_tvalid  out  1  valid to CRC stage.
- o_m_tdata  out  DATA_WIDTH  muxed data.
- o_m_tkeep  out  KEEP_BYTES  muxed keep.
- o_m_tlast  out  1  muxed last.
- o_m_tid  out  SRC_W  index of the granted source.
- i_m_tready  in  1  ready from CRC stage.
- o_busy  out  1  high while a grant is held.
- o_pkt_cnt  out  32  total packets forwarded; wraps at 2^32.

Behaviour:
- Interface: one clock (clk); reset srst is synchronous and active-high.
- Reset values:
  - state IDLE, grant 0, rr_ptr NUM_SRC-1 (source 0 wins first), o_pkt_cnt 0.
  - All o_s_tready 0, o_m_tvalid 0, o_busy 0.
- Reset mid-packet: the packet is abandoned with no tlast emitted. The bench treats this as a flush.
- FSM states:
  - IDLE: all o_s_tready=0, o_m_tvalid=0. If any i_s_tvalid is set, select the first valid source scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC. Register grant := selected and rr_ptr := selected, then go to PASS.
  - PASS:
    - o_m_tvalid = i_s_tvalid[grant].
    - o_m_tdata / o_m_tkeep / o_m_tlast = source[grant] fields (combinational mux).
    - o_s_tready[grant] = i_m_tready; all other o_s_tready are 0.
    - o_m_tid = grant (stable for the whole PASS).
    - o_busy = 1.
    - On transfer (o_m_tvalid & i_m_tready & o_m_tlast): o_pkt_cnt += 1, go to IDLE.
- Timing:
  - Arbitration costs exactly one IDLE cycle per packet: first beat of packet N+1 is no earlier than 2 cycles after tlast of packet N.
  - Zero added latency on data in PASS (combinational path tvalid/tready/data).
- Handshake rules:
  - Grant never changes mid-packet, regardless of other requesters.
  - A source dropping tvalid inside PASS only stalls; the grant is held.
  - Back-pressure: while i_m_tready=0, outputs mirror the granted source and AXI stability is the source's responsibility.
  - A single-beat packet (tlast on first beat) is legal: PASS lasts one cycle if ready is high.
- Arbitration edge cases:
  - Simultaneous requests are resolved strictly by the round-robin order above.
  - A source re-requesting immediately after its own packet loses to any other valid source.
  - If only one source is requesting, it is granted repeatedly with one bubble between packets.
  - Sources not in the grant see tready=0 and must hold their beat.
- o_pkt_cnt: 32-bit unsigned; 0xFFFFFFFF + 1 = 0.

Decomposition:
- Package axi_stream_crc_pkg:
  - typedef arb_state_t {IDLE, PASS}.
  - Default DATA_WIDTH and CRC_WIDTH constants, shared with the CRC block.
- Sub-module rr_arbiter_core (combinational): inputs req[NUM_SRC], ptr; outputs gnt_idx, gnt_any.
- Top level holds the FSM, grant/rr_ptr registers, the mux and the counter.

Test Plan:
- Reset, then srst=0 with no valid for 10 cycles -> o_m_tvalid=0, o_s_tready=0, o_busy=0, o_pkt_cnt=0.
- All 4 sources assert a 3-beat packet at cycle 0, i_m_tready=1 -> o_m_tid sequence 0,1,2,3; each packet 3 beats, one bubble between packets; o_pkt_cnt=4 at end; payload bit-exact.
- Source 2 mid-packet (beat 2 of 5) with i_m_tready toggled 1-0-0-1 and source 1 requesting -> o_m_tid stays 2 until tlast transfers; source 1 granted only after the IDLE bubble.
- Source 1 drops tvalid for 3 cycles mid-packet -> o_m_tvalid=0 for those cycles, grant and o_busy held, no other o_s_tready asserted.
- Only source 3 sends five single-beat packets -> granted each time, o_m_tlast=1 on every beat, throughput 1 beat per 2 cycles, o_pkt_cnt=5.
- Assert srst during beat 2 of source 0's packet, then source 1 and source 0 both valid -> all outputs reset next cycle; source 0 granted first after reset.

Source files
------------

// File: rtl/axi_stream_crc_arbiter_pkg.sv
// Shared types and constants for the AXI-Stream sideband-CRC path.
// Both the arbiter and the CRC block import this package.
package axi_stream_crc_pkg;

    localparam int DEFAULT_DATA_WIDTH = 512;
    localparam int DEFAULT_CRC_WIDTH  = 32;
    localparam int PKT_CNT_WIDTH      = 32;

    typedef enum logic {
        IDLE,
        PASS
    } arb_state_t;

endpackage

// File: rtl/axi_stream_crc_arbiter_rr.sv
// Combinational round-robin pick: the first requester after i_ptr wins,
// scanning i_ptr+1, i_ptr+2, ... modulo NUM_SRC.
module rr_arbiter_core #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [SRC_W-1:0]   i_ptr,
    output logic [SRC_W-1:0]   o_gnt_idx,
    output logic               o_gnt_any
);

    logic [SRC_W-1:0] w_idx;

    // Scan from farthest to nearest so the nearest requester after the pointer is the last write.
    always_comb begin
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        w_idx     = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            w_idx = SRC_W'((int'(i_ptr) + i) % NUM_SRC);
            if (i_req[w_idx]) begin
                o_gnt_idx = w_idx;
                o_gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_stream_crc_arbiter.sv
// Packet-granular round-robin arbiter feeding the sideband CRC stage.
// The grant is held from the first beat until the granted source's tlast transfers.
module axi_stream_crc_arbiter
    import axi_stream_crc_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int KEEP_BYTES = DATA_WIDTH / 8,
    parameter int NUM_SRC    = 4,
    parameter int SRC_W      = $clog2(NUM_SRC)
) (
    input  logic                           clk,
    input  logic                           srst,
    input  logic [NUM_SRC-1:0]             i_s_tvalid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]  i_s_tdata,
    input  logic [NUM_SRC*KEEP_BYTES-1:0]  i_s_tkeep,
    input  logic [NUM_SRC-1:0]             i_s_tlast,
    output logic [NUM_SRC-1:0]             o_s_tready,
    output logic                           o_m_tvalid,
    output logic [DATA_WIDTH-1:0]          o_m_tdata,
    output logic [KEEP_BYTES-1:0]          o_m_tkeep,
    output logic                           o_m_tlast,
    output logic [SRC_W-1:0]               o_m_tid,
    input  logic                           i_m_tready,
    output logic                           o_busy,
    output logic [PKT_CNT_WIDTH-1:0]       o_pkt_cnt
);

    arb_state_t               r_state;
    arb_state_t               w_state_nxt;
    logic [SRC_W-1:0]         r_grant;
    logic [SRC_W-1:0]         w_grant_nxt;
    logic [SRC_W-1:0]         r_rr_ptr;
    logic [SRC_W-1:0]         w_rr_ptr_nxt;
    logic [PKT_CNT_WIDTH-1:0] r_pkt_cnt;
    logic [PKT_CNT_WIDTH-1:0] w_pkt_cnt_nxt;
    logic [SRC_W-1:0]         w_gnt_idx;
    logic                     w_gnt_any;

    rr_arbiter_core #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr_core (
        .i_req     (i_s_tvalid),
        .i_ptr     (r_rr_ptr),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_any (w_gnt_any)
    );

    // Resetting the pointer to the last source makes source 0 the first winner.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_rr_ptr  <= SRC_W'(NUM_SRC - 1);
            r_pkt_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_pkt_cnt <= w_pkt_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_pkt_cnt_nxt = r_pkt_cnt;
        o_s_tready    = '0;
        o_m_tvalid    = 1'b0;
        o_busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_any) begin
                    w_grant_nxt  = w_gnt_idx;
                    w_rr_ptr_nxt = w_gnt_idx;
                    w_state_nxt  = PASS;
                end
            end
            PASS: begin
                o_busy              = 1'b1;
                o_m_tvalid          = i_s_tvalid[r_grant];
                o_s_tready[r_grant] = i_m_tready;
                if (i_s_tvalid[r_grant] && i_m_tready && i_s_tlast[r_grant]) begin
                    w_pkt_cnt_nxt = r_pkt_cnt + 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Payload is a pure mux on the registered grant, so PASS adds no latency.
    assign o_m_tdata = i_s_tdata[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
    assign o_m_tkeep = i_s_tkeep[int'(r_grant)*KEEP_BYTES +: KEEP_BYTES];
    assign o_m_tlast = i_s_tlast[r_grant];
    assign o_m_tid   = r_grant;
    assign o_pkt_cnt = r_pkt_cnt;

endmodule

// File: tb/tb_axi_stream_crc_arbiter.sv
// Directed bench for axi_stream_crc_arbiter: scripted sources, hand-tabulated
// expected grant/beat sequences per cycle.
module tb_axi_stream_crc_arbiter;

    localparam int DW = 512;
    localparam int KB = DW / 8;
    localparam int NS = 4;
    localparam int SW = 2;

    logic             clk = 1'b0;
    logic             srst;
    logic [NS-1:0]    i_s_tvalid;
    logic [NS*DW-1:0] i_s_tdata;
    logic [NS*KB-1:0] i_s_tkeep;
    logic [NS-1:0]    i_s_tlast;
    logic [NS-1:0]    o_s_tready;
    logic             o_m_tvalid;
    logic [DW-1:0]    o_m_tdata;
    logic [KB-1:0]    o_m_tkeep;
    logic             o_m_tlast;
    logic [SW-1:0]    o_m_tid;
    logic             i_m_tready;
    logic             o_busy;
    logic [31:0]      o_pkt_cnt;

    int nVec = 0;
    int nErr = 0;

    int srcPkts [NS];
    int srcLen  [NS];
    int srcBeat [NS];
    int srcIdx  [NS];
    bit srcStall[NS];

    axi_stream_crc_arbiter #(
        .DATA_WIDTH (DW),
        .KEEP_BYTES (KB),
        .NUM_SRC    (NS),
        .SRC_W      (SW)
    ) dut (
        .clk        (clk),
        .srst       (srst),
        .i_s_tvalid (i_s_tvalid),
        .i_s_tdata  (i_s_tdata),
        .i_s_tkeep  (i_s_tkeep),
        .i_s_tlast  (i_s_tlast),
        .o_s_tready (o_s_tready),
        .o_m_tvalid (o_m_tvalid),
        .o_m_tdata  (o_m_tdata),
        .o_m_tkeep  (o_m_tkeep),
        .o_m_tlast  (o_m_tlast),
        .o_m_tid    (o_m_tid),
        .i_m_tready (i_m_tready),
        .o_busy     (o_busy),
        .o_pkt_cnt  (o_pkt_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mkdata(input int src, input int pkt, input int beat);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++)
            d[i*32 +: 32] = {8'(8'hA0 + src), 8'(pkt), 8'(beat), 8'(i)};
        return d;
    endfunction

    function automatic logic [KB-1:0] mkkeep(input int src, input int beat);
        logic [KB-1:0] m;
        m = '1;
        return m >> (src * 4 + beat);
    endfunction

    task automatic load_src(input int k, input int npkts, input int len);
        srcPkts[k]  = npkts;
        srcLen[k]   = len;
        srcBeat[k]  = 0;
        srcIdx[k]   = 0;
        srcStall[k] = 1'b0;
    endtask

    // Sources present their current beat; outputs settle before the caller checks.
    task automatic drive_srcs();
        for (int k = 0; k < NS; k++) begin
            i_s_tvalid[k]          = (srcPkts[k] > 0) && !srcStall[k];
            i_s_tlast[k]           = (srcPkts[k] > 0) && (srcBeat[k] == srcLen[k] - 1);
            i_s_tdata[k*DW +: DW]  = mkdata(k, srcIdx[k], srcBeat[k]);
            i_s_tkeep[k*KB +: KB]  = mkkeep(k, srcBeat[k]);
        end
        #1;
    endtask

    task automatic advance();
        bit hs[NS];
        for (int k = 0; k < NS; k++) hs[k] = i_s_tvalid[k] && o_s_tready[k];
        @(posedge clk);
        #1;
        for (int k = 0; k < NS; k++) begin
            if (hs[k]) begin
                if (srcBeat[k] == srcLen[k] - 1) begin
                    srcBeat[k] = 0;
                    srcPkts[k] = srcPkts[k] - 1;
                    srcIdx[k]  = srcIdx[k] + 1;
                end else begin
                    srcBeat[k] = srcBeat[k] + 1;
                end
            end
        end
    endtask

    task automatic apply_reset();
        srst       = 1'b1;
        i_m_tready = 1'b0;
        for (int k = 0; k < NS; k++) load_src(k, 0, 1);
        drive_srcs();
        repeat (2) @(posedge clk);
        #1;
        srst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            drive_srcs();
            nVec++;
            if ({o_m_tvalid, o_busy, o_s_tready} !== 6'b0) begin
                nErr++;
                $display("[TB] FAIL reset_idle c=%0d got %b want 000000", c, {o_m_tvalid, o_busy, o_s_tready});
            end
            nVec++;
            if (o_pkt_cnt !== 32'd0) begin
                nErr++;
                $display("[TB] FAIL reset_cnt c=%0d got %0d want 0", c, o_pkt_cnt);
            end
            advance();
        end
    endtask

    task automatic test_round_robin();
        logic [8:0] obs, exp;
        int ph, tid, beat;
        bit v;
        apply_reset();
        i_m_tready = 1'b1;
        for (int k = 0; k < NS; k++) load_src(k, 1, 3);
        for (int c = 0; c < 17; c++) begin
            drive_srcs();
            ph   = c % 4;
            v    = (ph != 0);
            tid  = c / 4;
            beat = ph - 1;
            obs  = {o_m_tvalid, o_busy, o_s_tready, o_busy ? o_m_tid : 2'd0, o_m_tvalid & o_m_tlast};
            exp  = v ? {2'b11, 4'(1 << tid), 2'(tid), beat == 2} : 9'd0;
            nVec++;
            if (obs !== exp) begin
                nErr++;
                $display("[TB] FAIL rr_ctrl c=%0d got %b want %b", c, obs, exp);
            end
            if (v) begin
                nVec++;
                if (o_m_tdata !== mkdata(tid, 0, beat) || o_m_tkeep !== mkkeep(tid, beat)) begin
                    nErr++;
                    $display("[TB] FAIL rr_data c=%0d got %h keep %h want %h keep %h", c,
                             o_m_tdata, o_m_tkeep, mkdata(tid, 0, beat), mkkeep(tid, beat));
                end
            end
            advance();
        end
        nVec++;
        if (o_pkt_cnt !== 32'd4) begin
            nErr++;
            $display("[TB] FAIL rr_cnt got %0d want 4", o_pkt_cnt);
        end
    endtask

    task automatic test_backpressure();
        int tidT [12] = '{0, 2, 2, 2, 2, 2, 2, 2, 0, 1, 1, 0};
        int beatT[12] = '{0, 0, 1, 2, 3, 3, 3, 4, 0, 0, 1, 0};
        bit vT   [12] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 0};
        bit lastT[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
        bit rdyT [12] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        logic [8:0] obs, exp;
        apply_reset();
        load_src(2, 1, 5);
        for (int c = 0; c < 12; c++) begin
            if (c == 1) load_src(1, 1, 2);
            i_m_tready = rdyT[c];
            drive_srcs();
            obs = {o_m_tvalid, o_busy, o_s_tready, o_busy ? o_m_tid : 2'd0, o_m_tvalid & o_m_tlast};
            exp = vT[c] ? {2'b11, rdyT[c] ? 4'(1 << tidT[c]) : 4'b0, 2'(tidT[c]), lastT[c]} : 9'd0;
            nVec++;
            if (obs !== exp) begin
                nErr++;
                $display("[TB] FAIL bp_ctrl c=%0d got %b want %b", c, obs, exp);
            end
            if (vT[c]) begin
                nVec++;
                if (o_m_tdata !== mkdata(tidT[c], 0, beatT[c])) begin
                    nErr++;
                    $display("[TB] FAIL bp_data c=%0d got %h want %h", c, o_m_tdata, mkdata(tidT[c], 0, beatT[c]));
                end
            end
            advance();
        end
        nVec++;
        if (o_pkt_cnt !== 32'd2) begin
            nErr++;
            $display("[TB] FAIL bp_cnt got %0d want 2", o_pkt_cnt);
        end
    endtask

    task automatic test_valid_drop();
        int tidT [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        int beatT[11] = '{0, 0, 1, 0, 0, 0, 2, 3, 0, 0, 0};
        bit vT   [11] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0};
        bit busyT[11] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0};
        bit lastT[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        logic [8:0] obs, exp;
        apply_reset();
        i_m_tready = 1'b1;
        load_src(1, 1, 4);
        for (int c = 0; c < 11; c++) begin
            if (c == 1) load_src(0, 1, 1);
            srcStall[1] = (c >= 3) && (c <= 5);
            drive_srcs();
            obs = {o_m_tvalid, o_busy, o_s_tready, o_busy ? o_m_tid : 2'd0, o_m_tvalid & o_m_tlast};
            exp = busyT[c] ? {vT[c], 1'b1, 4'(1 << tidT[c]), 2'(tidT[c]), vT[c] & lastT[c]} : 9'd0;
            nVec++;
            if (obs !== exp) begin
                nErr++;
                $display("[TB] FAIL drop_ctrl c=%0d got %b want %b", c, obs, exp);
            end
            if (vT[c]) begin
                nVec++;
                if (o_m_tdata !== mkdata(tidT[c], 0, beatT[c])) begin
                    nErr++;
                    $display("[TB] FAIL drop_data c=%0d got %h want %h", c, o_m_tdata, mkdata(tidT[c], 0, beatT[c]));
                end
            end
            advance();
        end
        nVec++;
        if (o_pkt_cnt !== 32'd2) begin
            nErr++;
            $display("[TB] FAIL drop_cnt got %0d want 2", o_pkt_cnt);
        end
    endtask

    task automatic test_single_beat();
        logic [8:0] obs, exp;
        bit v;
        apply_reset();
        i_m_tready = 1'b1;
        load_src(3, 5, 1);
        for (int c = 0; c < 11; c++) begin
            drive_srcs();
            v   = (c % 2) == 1;
            obs = {o_m_tvalid, o_busy, o_s_tready, o_busy ? o_m_tid : 2'd0, o_m_tvalid & o_m_tlast};
            exp = v ? {2'b11, 4'b1000, 2'd3, 1'b1} : 9'd0;
            nVec++;
            if (obs !== exp) begin
                nErr++;
                $display("[TB] FAIL single_ctrl c=%0d got %b want %b", c, obs, exp);
            end
            if (v) begin
                nVec++;
                if (o_m_tdata !== mkdata(3, (c - 1) / 2, 0)) begin
                    nErr++;
                    $display("[TB] FAIL single_data c=%0d got %h want %h", c, o_m_tdata, mkdata(3, (c - 1) / 2, 0));
                end
            end
            advance();
        end
        nVec++;
        if (o_pkt_cnt !== 32'd5) begin
            nErr++;
            $display("[TB] FAIL single_cnt got %0d want 5", o_pkt_cnt);
        end
    endtask

    // Continues from the previous test so the counter and pointer hold non-reset values.
    task automatic test_reset_mid_packet();
        int tidT [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        int beatT[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        bit vT   [8] = '{0, 1, 1, 0, 1, 0, 1, 0};
        bit lastT[8] = '{0, 0, 0, 0, 1, 0, 1, 0};
        int cntT [8] = '{5, 5, 5, 0, 0, 1, 1, 2};
        logic [8:0] obs, exp;
        i_m_tready = 1'b1;
        load_src(0, 1, 3);
        for (int c = 0; c < 8; c++) begin
            srst = (c == 2);
            if (c == 3) begin
                load_src(0, 1, 1);
                load_src(1, 1, 1);
            end
            drive_srcs();
            obs = {o_m_tvalid, o_busy, o_s_tready, o_busy ? o_m_tid : 2'd0, o_m_tvalid & o_m_tlast};
            exp = vT[c] ? {2'b11, 4'(1 << tidT[c]), 2'(tidT[c]), lastT[c]} : 9'd0;
            nVec++;
            if (obs !== exp) begin
                nErr++;
                $display("[TB] FAIL rstmid_ctrl c=%0d got %b want %b", c, obs, exp);
            end
            if (vT[c]) begin
                nVec++;
                if (o_m_tdata !== mkdata(tidT[c], 0, beatT[c])) begin
                    nErr++;
                    $display("[TB] FAIL rstmid_data c=%0d got %h want %h", c, o_m_tdata, mkdata(tidT[c], 0, beatT[c]));
                end
            end
            nVec++;
            if (o_pkt_cnt !== 32'(cntT[c])) begin
                nErr++;
                $display("[TB] FAIL rstmid_cnt c=%0d got %0d want %0d", c, o_pkt_cnt, cntT[c]);
            end
            advance();
        end
    endtask

    initial begin
        srst       = 1'b1;
        i_m_tready = 1'b0;
        i_s_tvalid = '0;
        i_s_tdata  = '0;
        i_s_tkeep  = '0;
        i_s_tlast  = '0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_valid_drop();
        test_single_beat();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
